fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the 16-bit pipeline. It owns the fetch PC and the EPC register, and issues requests to instruction memory over a req/ready handshake. It applies redirects from branch/jump resolution, exception entry and RTI, halt, and pipeline stalls. The instruction/PC pair it presents downstream feeds the next-PC logic's `pc_inc` input.

## Interface
Parameters:
- `RESET_PC`, `16'h0000`: fetch address after reset.
- `EXC_VEC`, `16'h0002`: exception handler entry address.
- `NOP_INSTR`, `16'h0800`: instruction word presented in an empty or flushed slot.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: decode cannot accept; hold `if_*`.
- `redirect` in 1, `redirect_pc` in 16: taken branch/jump target, already resolved.
- `exc` in 1, `exc_pc` in 16: exception; `exc_pc` is saved to EPC.
- `rti` in 1: return from interrupt; fetch resumes at EPC.
- `halt` in 1: stop fetching permanently until reset.
- `imem_req` out 1, `imem_addr` out 16: fetch request to instruction memory.
- `imem_ready` in 1, `imem_data` in 16: returned word, valid when `imem_ready`=1.
- `if_valid` out 1, `if_instr` out 16, `if_pc` out 16, `if_pc_inc` out 16: fetched slot.
- `epc` out 16: saved exception PC.
- `halted` out 1: controller is in HALT.

## Operation
- States: IDLE, FETCH, HOLD, DRAIN, HALT.
- `imem_req` = 1 in FETCH and DRAIN only. `imem_addr` is a register and never changes while `imem_req`=1 and `imem_ready`=0.
- Event priority: `exc` > `halt` > `rti` > `redirect` > `stall`. "Event" below means `exc`, `rti` or `redirect`.
- Event target: `exc` → EXC_VEC, and EPC ← `exc_pc` on the same edge. `rti` → current EPC. `redirect` → `redirect_pc`.
- Every event flushes the slot: `if_valid`←0, `if_instr`←NOP_INSTR. This applies even when `stall`=1.
- IDLE: entered on reset; moves to FETCH on the next cycle.
- FETCH, with `imem_ready`=1:
  - If an event is present: discard the word, `imem_addr`←target, stay in FETCH.
  - If `halt`=1: go to HALT.
  - Else if `stall`=1 and `if_valid`=1: the word goes to the skid register and the state moves to HOLD.
  - Else: slot ← (word, `imem_addr`, `imem_addr`+2), `if_valid`←1, `imem_addr`←`imem_addr`+2, stay in FETCH.
- FETCH, with `imem_ready`=0:
  - If an event is present: latch the target and go to DRAIN.
  - If `halt`=1: set `halt_pend` and go to DRAIN.
- HOLD (`imem_req`=0):
  - If an event is present: drop the skid contents, `imem_addr`←target, go to FETCH.
  - If `halt`=1: go to HALT.
  - Else if `stall`=0: slot ← skid, go to FETCH at the next address.
- DRAIN: wait for `imem_ready`, then discard the word.
  - If `halt_pend`: go to HALT.
  - Else: `imem_addr`←latched target, go to FETCH.
  - A newer event arriving in DRAIN overwrites the latched target. `halt` arriving in DRAIN sets `halt_pend`.
- HALT: `imem_req`=0, `if_valid`=0, `halted`=1. Only `rst` exits HALT.
- Slot when `stall`=0 and no word is captured: `if_valid`←0, `if_instr`←NOP_INSTR (bubble).
- Address arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000, and no flag is raised. Bit 0 of targets is passed through unchanged.

## Timing
- Reset values: state IDLE, `imem_req`=0, `imem_addr`=RESET_PC, `if_valid`=0, `if_instr`=NOP_INSTR, `if_pc`=0, `if_pc_inc`=0, `epc`=0, `halted`=0, skid empty, `halt_pend`=0.
- Asserting `rst` mid-request abandons the request immediately. Memory must tolerate `imem_req` dropping in this case.
- First `imem_req` appears in the second cycle after `rst` deasserts.
- `imem_ready` may be asserted in the same cycle `imem_req` rises (zero wait). Sustained throughput is one word per cycle.
- `if_*` is registered: a word returned in cycle N appears at the slot in cycle N+1.
- Redirect latency: event in cycle N → `imem_addr`=target in cycle N+1 when there is no outstanding wait. Otherwise the target is issued in the cycle after the draining `imem_ready`.
- `epc` updates on the edge after `exc`.
- `halted` rises on the edge after entry to HALT.

## Structure
- Shared package `fetch_pkg` holds: state enum; constants RESET_PC, EXC_VEC, NOP_INSTR, PC_STEP (=2); opcode constants used elsewhere in the pipeline (NOP 5'b00001, HALT 5'b00000).
- One sub-module, `fetch_skid`: a one-entry instr/pc register with load, unload and clear controls.
- The target priority mux stays inline in `fetch_ctrl`.

## Test plan
- Reset, then `imem_ready` tied to 1: addresses 0x0000, 0x0002, 0x0004 are issued on consecutive cycles. `if_pc_inc` = `if_pc`+2. `if_valid` rises in cycle 3 after reset release.
- `stall`=1 for 3 cycles while `if_valid`=1 and a word returns: state goes to HOLD and the slot is held. On `stall`=0 the slot shows the skid word and the next `imem_addr` is the old address+2.
- `imem_ready` delayed 2 cycles while `redirect`=1 with `redirect_pc`=0x0040: `imem_addr` stays stable, the returned word is discarded, the next request is to 0x0040, and `if_valid`=0 in between.
- `exc`=1 with `exc_pc`=0x0010 in the same cycle as `redirect` to 0x0080: `epc`=0x0010 and the next fetch is 0x0002. A later `rti` fetches from 0x0010.
- `halt` with a request outstanding: the word is drained, `halted`=1, `imem_req` stays 0 for 10 cycles, and `rst` restarts fetch at 0x0000.
- `imem_addr`=0xFFFE fetched with no event: the next request is 0x0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch sequencer.
//   - fetch_state_e : fetch controller state encoding
//   - RESET_PC, EXC_VEC, NOP_INSTR, PC_STEP : address/instruction constants
//   - OP_NOP, OP_HALT : 5-bit opcodes shared with the rest of the pipeline
//   - pc_next()      : 16-bit modulo sequential-address helper
package fetch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StHold,
    StDrain,
    StHalt
  } fetch_state_e;

  localparam logic [4:0]  OP_NOP    = 5'b00001;
  localparam logic [4:0]  OP_HALT   = 5'b00000;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] EXC_VEC   = 16'h0002;
  // A NOP is the NOP opcode in the top five bits with all operand fields zero.
  localparam logic [15:0] NOP_INSTR = {OP_NOP, 11'b0};
  localparam logic [15:0] PC_STEP   = 16'd2;

  // Wraps silently at the top of the address space.
  function automatic logic [15:0] pc_next(input logic [15:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry instruction/PC holding register used when a word
// returns while decode is stalled.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   load_i                : capture instr_i/pc_i and mark the entry valid
//   unload_i              : entry has been consumed, mark it empty
//   clear_i               : discard the entry (flush)
//   instr_i, pc_i         : word and its fetch address to capture
//   valid_o, instr_o, pc_o: current entry contents
module fetch_skid (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        clear_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] pc_i,
  output logic        valid_o,
  output logic [15:0] instr_o,
  output logic [15:0] pc_o
);

  logic        valid_q;
  logic [15:0] instr_q;
  logic [15:0] pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      instr_q <= 16'h0000;
      pc_q    <= 16'h0000;
    end else if (clear_i || unload_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the fetch PC and EPC, issues
// requests over a req/ready handshake and presents one registered slot
// (instr, pc, pc+2) to decode.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   stall                      : decode cannot accept, hold the slot
//   redirect, redirect_pc      : resolved branch/jump target
//   exc, exc_pc                : exception entry, exc_pc saved to EPC
//   rti                        : return from interrupt, resume at EPC
//   halt                       : stop fetching until reset
//   imem_req, imem_addr        : fetch request (address is registered)
//   imem_ready, imem_data      : returned word
//   if_valid, if_instr, if_pc, if_pc_inc : fetched slot
//   epc                        : saved exception PC
//   halted                     : controller is halted
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = fetch_pkg::RESET_PC,
  parameter logic [15:0] EXC_VEC   = fetch_pkg::EXC_VEC,
  parameter logic [15:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        exc,
  input  logic [15:0] exc_pc,
  input  logic        rti,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_inc,
  output logic [15:0] epc,
  output logic        halted
);

  import fetch_pkg::*;

  fetch_state_e state_q, state_d;
  logic [15:0]  addr_q, addr_d;
  logic [15:0]  tgt_q, tgt_d;
  logic         halt_pend_q, halt_pend_d;
  logic [15:0]  epc_q, epc_d;
  logic         valid_q, valid_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  pc_inc_q, pc_inc_d;
  logic         halted_q;

  logic         ev_any;
  logic         ev_halt;
  logic [15:0]  ev_tgt;

  logic         skid_load, skid_unload, skid_clear;
  logic         skid_valid;
  logic [15:0]  skid_instr, skid_pc;

  fetch_skid u_skid (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .instr_i  (imem_data),
    .pc_i     (addr_q),
    .valid_o  (skid_valid),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  // Priority exc > halt > rti > redirect. A halt masks rti/redirect but not exc.
  always_comb begin
    ev_halt = halt & ~exc;
    ev_any  = exc | (~halt & (rti | redirect));
    if (exc) begin
      ev_tgt = EXC_VEC;
    end else if (rti) begin
      ev_tgt = epc_q;
    end else begin
      ev_tgt = redirect_pc;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tgt_d       = tgt_q;
    halt_pend_d = halt_pend_q;
    epc_d       = epc_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    pc_inc_d    = pc_inc_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    if (exc && (state_q != StHalt)) begin
      epc_d = exc_pc;
    end

    // Baseline slot behaviour; a captured word overrides it below.
    if (ev_any || !stall) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    unique case (state_q)
      StIdle: begin
        if (ev_halt) begin
          state_d = StHalt;
        end else begin
          state_d = StFetch;
          if (ev_any) begin
            addr_d = ev_tgt;
          end
        end
      end

      StFetch: begin
        if (imem_ready) begin
          if (ev_any) begin
            addr_d = ev_tgt;
          end else if (ev_halt) begin
            state_d = StHalt;
          end else if (stall && valid_q) begin
            skid_load = 1'b1;
            state_d   = StHold;
          end else begin
            valid_d  = 1'b1;
            instr_d  = imem_data;
            pc_d     = addr_q;
            pc_inc_d = pc_next(addr_q);
            addr_d   = pc_next(addr_q);
          end
        end else if (ev_any) begin
          tgt_d   = ev_tgt;
          state_d = StDrain;
        end else if (ev_halt) begin
          halt_pend_d = 1'b1;
          state_d     = StDrain;
        end
      end

      StHold: begin
        if (ev_any) begin
          skid_clear = 1'b1;
          addr_d     = ev_tgt;
          state_d    = StFetch;
        end else if (ev_halt) begin
          skid_clear = 1'b1;
          state_d    = StHalt;
        end else if (!stall) begin
          skid_unload = 1'b1;
          valid_d     = skid_valid;
          instr_d     = skid_instr;
          pc_d        = skid_pc;
          pc_inc_d    = pc_next(skid_pc);
          addr_d      = pc_next(addr_q);
          state_d     = StFetch;
        end
      end

      StDrain: begin
        if (ev_any) begin
          tgt_d = ev_tgt;
        end
        if (ev_halt) begin
          halt_pend_d = 1'b1;
        end
        // The outstanding word is always dropped; only the destination differs.
        if (imem_ready) begin
          if (halt_pend_d) begin
            halt_pend_d = 1'b0;
            state_d     = StHalt;
          end else begin
            addr_d  = tgt_d;
            state_d = StFetch;
          end
        end
      end

      StHalt: ;

      default: state_d = StIdle;
    endcase

    if (state_d == StHalt) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= RESET_PC;
      tgt_q       <= RESET_PC;
      halt_pend_q <= 1'b0;
      epc_q       <= 16'h0000;
      valid_q     <= 1'b0;
      instr_q     <= NOP_INSTR;
      pc_q        <= 16'h0000;
      pc_inc_q    <= 16'h0000;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tgt_q       <= tgt_d;
      halt_pend_q <= halt_pend_d;
      epc_q       <= epc_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      pc_inc_q    <= pc_inc_d;
      // Lags HALT entry by one edge.
      halted_q    <= (state_q == StHalt);
    end
  end

  assign imem_req  = (state_q == StFetch) || (state_q == StDrain);
  assign imem_addr = addr_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = pc_q;
  assign if_pc_inc = pc_inc_q;
  assign epc       = epc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl. Memory returns imem_addr ^ 16'hA500 so every
// expected instruction word can be worked out by hand.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        exc;
  logic [15:0] exc_pc;
  logic        rti;
  logic        halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_inc;
  logic [15:0] epc;
  logic        halted;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ 16'hA500;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .exc         (exc),
    .exc_pc      (exc_pc),
    .rti         (rti),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_data   (imem_data),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_inc   (if_pc_inc),
    .epc         (epc),
    .halted      (halted)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    exc = 1'b0; exc_pc = 16'h0000; rti = 1'b0; halt = 1'b0; imem_ready = 1'b1;
    step();
    step();
    check_eq("rst_req",    16'(imem_req),  16'd0);
    check_eq("rst_addr",   imem_addr,      16'h0000);
    check_eq("rst_valid",  16'(if_valid),  16'd0);
    check_eq("rst_instr",  if_instr,       16'h0800);
    check_eq("rst_pc",     if_pc,          16'h0000);
    check_eq("rst_pcinc",  if_pc_inc,      16'h0000);
    check_eq("rst_epc",    epc,            16'h0000);
    check_eq("rst_halted", 16'(halted),    16'd0);

    // Streaming with zero-wait memory.
    rst = 1'b0;
    step();                                       // cycle 2: first request
    check_eq("c2_req",   16'(imem_req), 16'd1);
    check_eq("c2_addr",  imem_addr,     16'h0000);
    check_eq("c2_valid", 16'(if_valid), 16'd0);
    step();                                       // cycle 3: slot valid
    check_eq("c3_addr",  imem_addr,     16'h0002);
    check_eq("c3_valid", 16'(if_valid), 16'd1);
    check_eq("c3_pc",    if_pc,         16'h0000);
    check_eq("c3_instr", if_instr,      16'hA500);
    check_eq("c3_pcinc", if_pc_inc,     16'h0002);
    step();
    check_eq("c4_addr",  imem_addr,     16'h0004);
    check_eq("c4_pc",    if_pc,         16'h0002);
    check_eq("c4_pcinc", if_pc_inc,     16'h0004);

    // Stall for three cycles: word from 0x0004 goes to the skid.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_req",  16'(imem_req), 16'd0);
      check_eq("hold_pc",   if_pc,         16'h0002);
      check_eq("hold_addr", imem_addr,     16'h0004);
    end
    stall = 1'b0;
    step();
    check_eq("unskid_valid", 16'(if_valid), 16'd1);
    check_eq("unskid_pc",    if_pc,         16'h0004);
    check_eq("unskid_instr", if_instr,      16'hA504);
    check_eq("unskid_addr",  imem_addr,     16'h0006);
    check_eq("unskid_req",   16'(imem_req), 16'd1);
    step();
    check_eq("post_pc",   if_pc,     16'h0006);
    check_eq("post_addr", imem_addr, 16'h0008);

    // Redirect while the request at 0x0008 waits two cycles.
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    check_eq("drn1_addr",  imem_addr,     16'h0008);
    check_eq("drn1_req",   16'(imem_req), 16'd1);
    check_eq("drn1_valid", 16'(if_valid), 16'd0);
    check_eq("drn1_instr", if_instr,      16'h0800);
    redirect = 1'b0;
    step();
    check_eq("drn2_addr",  imem_addr,     16'h0008);
    check_eq("drn2_valid", 16'(if_valid), 16'd0);
    imem_ready = 1'b1;
    step();
    check_eq("drn3_addr",  imem_addr,     16'h0040);
    check_eq("drn3_valid", 16'(if_valid), 16'd0);
    step();
    check_eq("tgt_pc",    if_pc,     16'h0040);
    check_eq("tgt_instr", if_instr,  16'hA540);
    check_eq("tgt_addr",  imem_addr, 16'h0042);

    // Exception beats a simultaneous redirect.
    exc = 1'b1; exc_pc = 16'h0010; redirect = 1'b1; redirect_pc = 16'h0080;
    step();
    check_eq("exc_addr",  imem_addr,     16'h0002);
    check_eq("exc_epc",   epc,           16'h0010);
    check_eq("exc_valid", 16'(if_valid), 16'd0);
    exc = 1'b0; redirect = 1'b0;
    step();
    check_eq("vec_pc",   if_pc,     16'h0002);
    check_eq("vec_addr", imem_addr, 16'h0004);
    rti = 1'b1;
    step();
    check_eq("rti_addr", imem_addr, 16'h0010);
    rti = 1'b0;
    step();
    check_eq("rti_pc", if_pc, 16'h0010);

    // Halt with the request at 0x0012 outstanding.
    imem_ready = 1'b0; halt = 1'b1;
    step();
    check_eq("hlt_drain_req", 16'(imem_req), 16'd1);
    halt = 1'b0; imem_ready = 1'b1;
    step();
    check_eq("hlt_req",    16'(imem_req), 16'd0);
    check_eq("hlt_valid",  16'(if_valid), 16'd0);
    check_eq("hlt_early",  16'(halted),   16'd0);
    step();
    check_eq("hlt_halted", 16'(halted), 16'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("hlt_idle_req", 16'(imem_req), 16'd0);
    end
    check_eq("hlt_still", 16'(halted), 16'd1);

    rst = 1'b1;
    step();
    check_eq("rrst_halted", 16'(halted), 16'd0);
    rst = 1'b0;
    step();
    check_eq("rrst_req",  16'(imem_req), 16'd1);
    check_eq("rrst_addr", imem_addr,     16'h0000);

    // Wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    check_eq("wrap_tgt", imem_addr, 16'hFFFE);
    redirect = 1'b0;
    step();
    check_eq("wrap_pc",    if_pc,     16'hFFFE);
    check_eq("wrap_pcinc", if_pc_inc, 16'h0000);
    check_eq("wrap_addr",  imem_addr, 16'h0000);

    // Odd target passes bit 0 through.
    redirect = 1'b1; redirect_pc = 16'h0031;
    step();
    check_eq("odd_addr", imem_addr, 16'h0031);
    redirect = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
